carfield_domain_seq: RTL and testbench

// - Runtime power-up/power-down sequencer for NumDomains clock domains (periph, safed, secured, pulp, spatz, l2).
// - Per domain: drives clock enable, active-low domain reset and isolation in a fixed order, and holds a programmable clock-divider value.
// - Sits between the SoC control registers (requests, divider writes) and the per-domain clock dividers, reset synchronisers and isolation cells.

---
 rtl/carfield_pkg.sv | 53 +++++
 rtl/carfield_domain_fsm.sv | 135 +++++++++++++
 rtl/carfield_domain_seq.sv | 52 +++++
 tb/tb_carfield_domain_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/carfield_pkg.sv
// Shared types and defaults for the Carfield runtime domain power sequencer.
// Domain index order: periph, safed, secured, pulp, spatz, l2.
package carfield_pkg;

  localparam int unsigned CarfieldNumDomains = 6;
  localparam int unsigned CarfieldDivWidth   = 8;
  localparam int unsigned CarfieldRstDelay   = 16;
  localparam int unsigned CarfieldIsoDelay   = 4;

  // Per-domain clock-divider reset defaults
  localparam logic [CarfieldDivWidth-1:0] CarfieldPeriphDiv  = CarfieldDivWidth'(1);
  localparam logic [CarfieldDivWidth-1:0] CarfieldSafedDiv   = CarfieldDivWidth'(1);
  localparam logic [CarfieldDivWidth-1:0] CarfieldSecuredDiv = CarfieldDivWidth'(1);
  localparam logic [CarfieldDivWidth-1:0] CarfieldPulpDiv    = CarfieldDivWidth'(1);
  localparam logic [CarfieldDivWidth-1:0] CarfieldSpatzDiv   = CarfieldDivWidth'(1);
  localparam logic [CarfieldDivWidth-1:0] CarfieldL2Div      = CarfieldDivWidth'(1);

  localparam logic [CarfieldNumDomains-1:0][CarfieldDivWidth-1:0] CarfieldDefaultDiv = {
    CarfieldL2Div, CarfieldSpatzDiv, CarfieldPulpDiv,
    CarfieldSecuredDiv, CarfieldSafedDiv, CarfieldPeriphDiv
  };

  typedef enum logic [2:0] {
    OFF,
    CLK_UP,
    RST_REL,
    ON,
    ISO_ON,
    RST_ASSERT
  } carfield_dom_state_e;

  typedef struct packed {
    logic clk_en;
    logic rst_n;
    logic iso;
    logic on;
    logic busy;
  } carfield_dom_out_t;

  // Output pattern a domain presents while sitting in a given state
  function automatic carfield_dom_out_t dom_outputs(input carfield_dom_state_e s);
    carfield_dom_out_t o;
    o = '{clk_en: 1'b0, rst_n: 1'b0, iso: 1'b1, on: 1'b0, busy: 1'b0};
    case (s)
      CLK_UP, RST_ASSERT: o = '{clk_en: 1'b1, rst_n: 1'b0, iso: 1'b1, on: 1'b0, busy: 1'b1};
      RST_REL, ISO_ON:    o = '{clk_en: 1'b1, rst_n: 1'b1, iso: 1'b1, on: 1'b0, busy: 1'b1};
      ON:                 o = '{clk_en: 1'b1, rst_n: 1'b1, iso: 1'b0, on: 1'b1, busy: 1'b0};
      default:            ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/carfield_domain_fsm.sv
// Single-domain power sequencer: clock enable, reset and isolation ordering,
// plus the domain's clock-divider register with a zero-write error flag.
module carfield_domain_fsm
  import carfield_pkg::*;
#(
  parameter int unsigned          DivWidth   = CarfieldDivWidth,
  parameter int unsigned          RstDelay   = CarfieldRstDelay,
  parameter int unsigned          IsoDelay   = CarfieldIsoDelay,
  parameter logic [DivWidth-1:0]  DefaultDiv = DivWidth'(1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_on_i,
  input  logic                req_off_i,
  input  logic                div_valid_i,
  input  logic [DivWidth-1:0] div_value_i,
  output logic                div_ready_o,
  output logic [DivWidth-1:0] div_value_o,
  output logic                clk_en_o,
  output logic                domain_rst_no,
  output logic                iso_o,
  output logic                on_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned   MaxDelay = (RstDelay > IsoDelay) ? RstDelay : IsoDelay;
  localparam int unsigned   CntW     = $clog2(MaxDelay + 1);
  localparam logic [CntW-1:0] RstLoad = CntW'(RstDelay - 1);
  localparam logic [CntW-1:0] IsoLoad = CntW'(IsoDelay - 1);

  if (RstDelay == 0) begin : g_bad_rst_delay
    $error("RstDelay must be at least 1");
  end
  if (IsoDelay == 0) begin : g_bad_iso_delay
    $error("IsoDelay must be at least 1");
  end
  if (DefaultDiv == '0) begin : g_bad_default_div
    $error("DefaultDiv entries must be nonzero");
  end

  carfield_dom_state_e state;
  logic [CntW-1:0]     cnt;
  carfield_dom_out_t   outs;
  logic [DivWidth-1:0] div_q;
  logic                err_q;

  // The divider may only be rewritten while the domain clock is stopped
  assign div_ready_o = (state == OFF);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= OFF;
      cnt   <= '0;
      outs  <= dom_outputs(OFF);
      div_q <= DefaultDiv;
      err_q <= 1'b0;
    end else begin
      if (div_valid_i && div_ready_o) begin
        if (div_value_i != '0) begin
          div_q <= div_value_i;
          err_q <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end

      // Requests outside OFF/ON are dropped; timed states just count down
      case (state)
        OFF: begin
          if (req_on_i && !req_off_i) begin
            state <= CLK_UP;
            cnt   <= RstLoad;
            outs  <= dom_outputs(CLK_UP);
          end
        end
        CLK_UP: begin
          if (cnt == '0) begin
            state <= RST_REL;
            cnt   <= IsoLoad;
            outs  <= dom_outputs(RST_REL);
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        RST_REL: begin
          if (cnt == '0) begin
            state <= ON;
            outs  <= dom_outputs(ON);
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        ON: begin
          if (req_off_i) begin
            state <= ISO_ON;
            cnt   <= IsoLoad;
            outs  <= dom_outputs(ISO_ON);
          end
        end
        ISO_ON: begin
          if (cnt == '0) begin
            state <= RST_ASSERT;
            cnt   <= RstLoad;
            outs  <= dom_outputs(RST_ASSERT);
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        RST_ASSERT: begin
          if (cnt == '0) begin
            state <= OFF;
            outs  <= dom_outputs(OFF);
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        default: begin
          state <= OFF;
          cnt   <= '0;
          outs  <= dom_outputs(OFF);
        end
      endcase
    end
  end

  assign div_value_o   = div_q;
  assign err_o         = err_q;
  assign clk_en_o      = outs.clk_en;
  assign domain_rst_no = outs.rst_n;
  assign iso_o         = outs.iso;
  assign on_o          = outs.on;
  assign busy_o        = outs.busy;

endmodule

// File: rtl/carfield_domain_seq.sv
// Runtime power-up/power-down sequencer for all Carfield clock domains:
// one independent domain FSM per domain, packed onto flat SoC-facing ports.
module carfield_domain_seq
  import carfield_pkg::*;
#(
  parameter int unsigned NumDomains = CarfieldNumDomains,
  parameter int unsigned DivWidth   = CarfieldDivWidth,
  parameter int unsigned RstDelay   = CarfieldRstDelay,
  parameter int unsigned IsoDelay   = CarfieldIsoDelay,
  parameter logic [NumDomains-1:0][DivWidth-1:0] DefaultDiv = CarfieldDefaultDiv
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumDomains-1:0]          req_on_i,
  input  logic [NumDomains-1:0]          req_off_i,
  input  logic [NumDomains-1:0]          div_valid_i,
  input  logic [NumDomains*DivWidth-1:0] div_value_i,
  output logic [NumDomains-1:0]          div_ready_o,
  output logic [NumDomains*DivWidth-1:0] div_value_o,
  output logic [NumDomains-1:0]          clk_en_o,
  output logic [NumDomains-1:0]          domain_rst_no,
  output logic [NumDomains-1:0]          iso_o,
  output logic [NumDomains-1:0]          on_o,
  output logic [NumDomains-1:0]          busy_o,
  output logic [NumDomains-1:0]          err_o
);

  for (genvar i = 0; i < NumDomains; i++) begin : g_dom
    carfield_domain_fsm #(
      .DivWidth   (DivWidth),
      .RstDelay   (RstDelay),
      .IsoDelay   (IsoDelay),
      .DefaultDiv (DefaultDiv[i])
    ) u_fsm (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_on_i      (req_on_i[i]),
      .req_off_i     (req_off_i[i]),
      .div_valid_i   (div_valid_i[i]),
      .div_value_i   (div_value_i[i*DivWidth +: DivWidth]),
      .div_ready_o   (div_ready_o[i]),
      .div_value_o   (div_value_o[i*DivWidth +: DivWidth]),
      .clk_en_o      (clk_en_o[i]),
      .domain_rst_no (domain_rst_no[i]),
      .iso_o         (iso_o[i]),
      .on_o          (on_o[i]),
      .busy_o        (busy_o[i]),
      .err_o         (err_o[i])
    );
  end

endmodule

// File: tb/tb_carfield_domain_seq.sv
// Bench for carfield_domain_seq: directed sequences plus random traffic,
// checked every cycle against a phase/elapsed-time model of each domain.
module tb_carfield_domain_seq;

  localparam int ND = 6;
  localparam int DW = 8;
  localparam int RD = 16;
  localparam int ID = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [ND-1:0]    req_on, req_off, div_valid;
  logic [ND*DW-1:0] div_value;
  logic [ND-1:0]    div_ready;
  logic [ND*DW-1:0] div_out;
  logic [ND-1:0]    clk_en, rst_n, iso, on, busy, err;

  carfield_domain_seq dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_on_i      (req_on),
    .req_off_i     (req_off),
    .div_valid_i   (div_valid),
    .div_value_i   (div_value),
    .div_ready_o   (div_ready),
    .div_value_o   (div_out),
    .clk_en_o      (clk_en),
    .domain_rst_no (rst_n),
    .iso_o         (iso),
    .on_o          (on),
    .busy_o        (busy),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int failures  = 0;
  int cyc       = 0;

  // Model: mode 0=off, 1=powering up, 2=on, 3=powering down; el = cycles in sequence
  int            mode [ND];
  int            el   [ND];
  logic [DW-1:0] mdiv [ND];
  logic          merr [ND];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // {clk_en, rst_n, iso, on, busy}
  function automatic logic [4:0] exp_outs(input int m, input int e);
    case (m)
      1:       return (e <= RD) ? 5'b10101 : 5'b11101;
      2:       return 5'b11010;
      3:       return (e <= ID) ? 5'b11101 : 5'b10101;
      default: return 5'b00100;
    endcase
  endfunction

  task automatic model_edge();
    logic [DW-1:0] v;
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        mode[d] = 0; el[d] = 0; mdiv[d] = DW'(1); merr[d] = 1'b0;
      end else begin
        if (div_valid[d] && mode[d] == 0) begin
          v = div_value[d*DW +: DW];
          if (v != '0) begin mdiv[d] = v; merr[d] = 1'b0; end
          else merr[d] = 1'b1;
        end
        case (mode[d])
          0: if (req_on[d] && !req_off[d]) begin mode[d] = 1; el[d] = 1; end
          2: if (req_off[d]) begin mode[d] = 3; el[d] = 1; end
          1: begin el[d]++; if (el[d] > RD + ID) mode[d] = 2; end
          3: begin el[d]++; if (el[d] > RD + ID) mode[d] = 0; end
          default: mode[d] = 0;
        endcase
      end
    end
  endtask

  task automatic check_all();
    logic [ND-1:0]    ce, rn, is, onv, bz, rdy, er;
    logic [ND*DW-1:0] dv;
    logic [4:0]       o;
    for (int d = 0; d < ND; d++) begin
      o = exp_outs(mode[d], el[d]);
      ce[d] = o[4]; rn[d] = o[3]; is[d] = o[2]; onv[d] = o[1]; bz[d] = o[0];
      rdy[d] = (mode[d] == 0);
      er[d]  = merr[d];
      dv[d*DW +: DW] = mdiv[d];
    end
    chk("clk_en", 64'(clk_en), 64'(ce));
    chk("domain_rst_n", 64'(rst_n), 64'(rn));
    chk("iso", 64'(iso), 64'(is));
    chk("on", 64'(on), 64'(onv));
    chk("busy", 64'(busy), 64'(bz));
    chk("div_ready", 64'(div_ready), 64'(rdy));
    chk("err", 64'(err), 64'(er));
    chk("div_value", 64'(div_out), 64'(dv));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_all();
    req_on  = '0;
    req_off = '0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic div_write(input int d, input logic [DW-1:0] v);
    div_valid[d] = 1'b1;
    div_value[d*DW +: DW] = v;
    tick();
    div_valid[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_on = '0; req_off = '0; div_valid = '0; div_value = '0;
    ticks(2);
    rst = 1'b0;
    chk("reset_clk_en", 64'(clk_en), 64'(0));
    chk("reset_rst_n", 64'(rst_n), 64'(0));
    chk("reset_iso", 64'(iso), 64'(6'h3f));
    chk("reset_div", 64'(div_out), 64'(48'h0101_0101_0101));

    // Power-up latency on domain 0
    req_on[0] = 1'b1; cyc = 0;
    tick();      chk("up_clk_en_at1", 64'(clk_en[0]), 64'(1));
    ticks(15);   chk("up_rst_n_at16", 64'(rst_n[0]), 64'(0));
    tick();      chk("up_rst_n_at17", 64'(rst_n[0]), 64'(1));
    ticks(3);    chk("up_on_at20", 64'(on[0]), 64'(0));
                 chk("up_busy_at20", 64'(busy[0]), 64'(1));
    tick();      chk("up_on_at21", 64'(on[0]), 64'(1));
                 chk("up_iso_at21", 64'(iso[0]), 64'(0));

    // Power-down latency on domain 0
    req_off[0] = 1'b1; cyc = 0;
    tick();      chk("dn_iso_at1", 64'(iso[0]), 64'(1));
    ticks(3);    chk("dn_rst_n_at4", 64'(rst_n[0]), 64'(1));
    tick();      chk("dn_rst_n_at5", 64'(rst_n[0]), 64'(0));
    ticks(15);   chk("dn_clk_en_at20", 64'(clk_en[0]), 64'(1));
    tick();      chk("dn_clk_en_at21", 64'(clk_en[0]), 64'(0));
                 chk("dn_ready_at21", 64'(div_ready[0]), 64'(1));

    // Divider writes on domain 2 while off
    div_write(2, 8'h04);
    chk("div2_is4", 64'(div_out[2*DW +: DW]), 64'(4));
    div_write(2, 8'h00);
    chk("div2_zero_keeps4", 64'(div_out[2*DW +: DW]), 64'(4));
    chk("div2_zero_err", 64'(err[2]), 64'(1));
    div_write(2, 8'h02);
    chk("div2_err_clear", 64'(err[2]), 64'(0));

    // Domain 1: divider write held from ON through power-down
    req_on[1] = 1'b1;
    ticks(21);
    chk("d1_on", 64'(on[1]), 64'(1));
    div_valid[1] = 1'b1; div_value[1*DW +: DW] = 8'h09; req_off[1] = 1'b1; cyc = 0;
    tick();      chk("d1_ready_stall", 64'(div_ready[1]), 64'(0));
    ticks(20);   chk("d1_ready_off", 64'(div_ready[1]), 64'(1));
                 chk("d1_div_unchanged", 64'(div_out[1*DW +: DW]), 64'(1));
    tick();      chk("d1_div_transfer", 64'(div_out[1*DW +: DW]), 64'(9));
    div_valid[1] = 1'b0;

    // Domain 3: off-request during power-up dropped, then both requests in ON
    req_on[3] = 1'b1; cyc = 0;
    ticks(5);
    req_off[3] = 1'b1;
    ticks(15);   chk("d3_on_at20", 64'(on[3]), 64'(0));
    tick();      chk("d3_on_at21", 64'(on[3]), 64'(1));
    req_on[3] = 1'b1; req_off[3] = 1'b1;
    tick();      chk("d3_both_iso", 64'(iso[3]), 64'(1));
                 chk("d3_both_busy", 64'(busy[3]), 64'(1));
    ticks(20);

    // Domain 4: both requests while off keep it off
    req_on[4] = 1'b1; req_off[4] = 1'b1;
    tick();      chk("d4_both_off", 64'(clk_en[4]), 64'(0));

    // Reset during power-up of every domain
    req_on = '1; cyc = 0;
    ticks(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_clk_en", 64'(clk_en), 64'(0));
    chk("mid_rst_rst_n", 64'(rst_n), 64'(0));
    chk("mid_rst_iso", 64'(iso), 64'(6'h3f));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_div", 64'(div_out), 64'(48'h0101_0101_0101));

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int d = 0; d < ND; d++) begin
        req_on[d]    = ($urandom_range(0, 9) == 0);
        req_off[d]   = ($urandom_range(0, 9) == 0);
        div_valid[d] = ($urandom_range(0, 3) == 0);
        div_value[d*DW +: DW] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      end
      tick();
    end
    rst = 1'b0;
    div_valid = '0;

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
